// File: rtl/timer_mc_pkg.sv
// Shared definitions for the multi-channel timer: register offsets, CTRL
// field positions, the CTRL payload struct and its write-decode helper.
// Optional feature macro: TIMER_MC_PRESCALE_EN (enables the CTRL[15:8] PSC field).
package timer_mc_pkg;

    localparam int unsigned BUS_W    = 32;
    localparam int unsigned ADDR_W   = 30;
    localparam int unsigned CH_IDX_W = 3;   // enough index bits for the largest build (8 channels)
    localparam int unsigned PSC_W    = 8;
    localparam int unsigned CTRL_W   = 16;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STAT   = 2'd1;
    localparam logic [1:0] REG_EXPIRE = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    localparam int unsigned CTRL_START_BIT    = 0;
    localparam int unsigned CTRL_PERIODIC_BIT = 1;
    localparam int unsigned CTRL_IE_BIT       = 2;
    localparam int unsigned CTRL_PSC_LSB      = 8;
    localparam int unsigned CTRL_PSC_MSB      = 15;

`ifdef TIMER_MC_PRESCALE_EN
    localparam logic [CTRL_W-1:0] CTRL_WR_MASK = 16'hFF07;
`else
    localparam logic [CTRL_W-1:0] CTRL_WR_MASK = 16'h0007;
`endif

    // CTRL register image; bit layout matches the software-visible word.
    typedef struct packed {
        logic [PSC_W-1:0] psc;
        logic [4:0]       rsvd;
        logic             ie;
        logic             periodic;
        logic             start;
    } ctrl_t;

    // Writable bits only; reserved (and PSC when prescaling is absent) stay zero.
    function automatic ctrl_t ctrl_from_word(input logic [CTRL_W-1:0] w);
        return ctrl_t'(w & CTRL_WR_MASK);
    endfunction

endpackage

// File: rtl/timer_mc_ch.sv
// One timer channel: CTRL, STAT.flag, EXPIRE, COUNT and optional prescaler.
// Ports: clk, reset (sync, active high); wr_en/reg_sel/wr_data bus write for
// this channel; rd_word_c combinational read of reg_sel; flag, ie for irq.
// Optional feature macro: TIMER_MC_PRESCALE_EN.
module timer_mc_ch
    import timer_mc_pkg::*;
#(
    parameter int unsigned COUNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [1:0]       reg_sel,
    input  logic [BUS_W-1:0] wr_data,
    output logic [BUS_W-1:0] rd_word_c,
    output logic             flag,
    output logic             ie
);

    ctrl_t              ctrl;
    logic [COUNT_W-1:0] expire;
    logic [COUNT_W-1:0] count;
    logic               tick_c;
    logic               hit_c;
    logic               wr_ctrl_c;
    logic               wr_stat_c;
    logic               wr_expire_c;
    logic               wr_count_c;
    logic               unused_wr_data_c;

    assign wr_ctrl_c        = wr_en && (reg_sel == REG_CTRL);
    assign wr_stat_c        = wr_en && (reg_sel == REG_STAT);
    assign wr_expire_c      = wr_en && (reg_sel == REG_EXPIRE);
    assign wr_count_c       = wr_en && (reg_sel == REG_COUNT);
    assign unused_wr_data_c = ^wr_data;

`ifdef TIMER_MC_PRESCALE_EN
    logic [PSC_W-1:0] psc_cnt;

    // Count only when the private prescaler reaches PSC; it idles at 0 while stopped.
    assign tick_c = ctrl.start && (psc_cnt == ctrl.psc);

    always_ff @(posedge clk) begin
        if (reset || !ctrl.start || tick_c) psc_cnt <= '0;
        else                                psc_cnt <= psc_cnt + PSC_W'(1);
    end
`else
    assign tick_c = ctrl.start;
`endif

    assign hit_c = tick_c && (count == expire);

    // Hardware update first; later bus-write assignments override it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl   <= '0;
            expire <= '0;
            count  <= '0;
            flag   <= 1'b0;
        end else begin
            if (hit_c) begin
                count <= '0;
                if (!ctrl.periodic) ctrl.start <= 1'b0;
            end else if (tick_c) begin
                count <= count + COUNT_W'(1);
            end
            if (wr_ctrl_c)   ctrl   <= ctrl_from_word(wr_data[CTRL_W-1:0]);
            if (wr_expire_c) expire <= wr_data[COUNT_W-1:0];
            if (wr_count_c)  count  <= wr_data[COUNT_W-1:0];
            // A hardware set beats a same-cycle software clear.
            if (hit_c)          flag <= 1'b1;
            else if (wr_stat_c) flag <= 1'b0;
        end
    end

    assign ie = ctrl.ie;

    // Register read, zero-extended.
    always_comb begin
        rd_word_c = '0;
        case (reg_sel)
            REG_CTRL:   rd_word_c = BUS_W'(ctrl);
            REG_STAT:   rd_word_c = BUS_W'(flag);
            REG_EXPIRE: rd_word_c = BUS_W'(expire);
            default:    rd_word_c = BUS_W'(count);
        endcase
    end

endmodule

// File: rtl/timer_mc.sv
// Multi-channel timer bus slave: bus decode, read mux, rdy_ and irq registers.
// Ports: clk, reset (sync, active high); cs_, as_ (active low), rw (1=read),
// addr (word address), wr_data; rd_data, rdy_ (active low), irq.
// Channel index is addr[4:2]; indices >= NUM_CH read 0 and ignore writes.
// Optional feature macro: TIMER_MC_PRESCALE_EN.
module timer_mc
    import timer_mc_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned COUNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BUS_W-1:0]  wr_data,
    output logic [BUS_W-1:0]  rd_data,
    output logic              rdy_,
    output logic              irq
);

    logic                access_c;
    logic                wr_acc_c;
    logic [CH_IDX_W-1:0] ch_idx_c;
    logic [1:0]          reg_sel_c;
    logic [NUM_CH-1:0]   wr_en_c;
    logic [NUM_CH-1:0]   flag_v;
    logic [NUM_CH-1:0]   ie_v;
    logic [BUS_W-1:0]    rd_word_c [NUM_CH];
    logic [BUS_W-1:0]    rd_mux_c;
    logic                unused_addr_c;

    assign access_c      = !cs_ && !as_;
    assign wr_acc_c      = access_c && !rw;
    assign ch_idx_c      = addr[2 +: CH_IDX_W];
    assign reg_sel_c     = addr[1:0];
    assign unused_addr_c = ^addr[ADDR_W-1:CH_IDX_W+2];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_en_c[i] = wr_acc_c && (ch_idx_c == CH_IDX_W'(i));

        timer_mc_ch #(.COUNT_W(COUNT_W)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .wr_en     (wr_en_c[i]),
            .reg_sel   (reg_sel_c),
            .wr_data   (wr_data),
            .rd_word_c (rd_word_c[i]),
            .flag      (flag_v[i]),
            .ie        (ie_v[i])
        );
    end

    // Read mux; an unmatched (out-of-range) index leaves the default 0.
    always_comb begin
        rd_mux_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_idx_c == CH_IDX_W'(i)) rd_mux_c = rd_word_c[i];
        end
    end

    // Bus response one cycle after the sampled access; irq OR-reduce.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
            rdy_    <= 1'b1;
            irq     <= 1'b0;
        end else begin
            rdy_    <= !access_c;
            rd_data <= (access_c && rw) ? rd_mux_c : '0;
            irq     <= |(flag_v & ie_v);
        end
    end

endmodule

// File: tb/tb_timer_mc.sv
module tb_timer_mc;

    localparam int R_CTRL = 0, R_STAT = 1, R_EXP = 2, R_CNT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs_ = 1'b1, as_ = 1'b1, rw = 1'b1;
    logic [29:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        rdy_;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    timer_mc #(.NUM_CH(4), .COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        int          ch;
        int          rg;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // All calls start and end #1 after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle access: sampled at the next edge, response looked at #1 later.
    task automatic bus(input logic r, input int ch, input int rg, input logic [31:0] wd,
                       output logic [31:0] d, output logic rdy);
        cs_ = 1'b0; as_ = 1'b0; rw = r;
        addr = 30'(ch * 4 + rg); wr_data = wd;
        @(posedge clk); #1;
        cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0; wr_data = '0;
        d = rd_data; rdy = rdy_;
    endtask

    task automatic wr(input int ch, input int rg, input logic [31:0] wd);
        logic [31:0] d;
        logic        r;
        bus(1'b0, ch, rg, wd, d, r);
        chk("wr_rdy", 32'(r), 32'(1'b0));
    endtask

    task automatic rd(input int ch, input int rg, input logic [31:0] exp, input string nm);
        logic [31:0] d;
        logic        r;
        bus(1'b1, ch, rg, 32'h0, d, r);
        chk({nm, "_rdy"}, 32'(r), 32'(1'b0));
        chk(nm, d, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        int c, e, k, per, ie, st;
        logic [31:0] exp_cnt;

        tick(2);
        reset = 1'b0;
        chk("reset_rdy", 32'(rdy_), 32'(1'b1));
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_irq", 32'(irq), 32'(1'b0));

        // Table: reset values of every register, then plain register traffic.
        for (int ch = 0; ch < 4; ch++)
            for (int rg = 0; rg < 4; rg++)
                tbl.push_back('{1'b1, ch, rg, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 1, R_EXP, 32'h0000_00A5, 32'h0});
        tbl.push_back('{1'b1, 1, R_EXP, 32'h0, 32'h0000_00A5});
`ifdef TIMER_MC_PRESCALE_EN
        tbl.push_back('{1'b0, 2, R_CTRL, 32'hFFFF_0306, 32'h0});
        tbl.push_back('{1'b1, 2, R_CTRL, 32'h0, 32'h0000_0306});
`else
        tbl.push_back('{1'b0, 2, R_CTRL, 32'hFFFF_0306, 32'h0});
        tbl.push_back('{1'b1, 2, R_CTRL, 32'h0, 32'h0000_0006});
`endif
        tbl.push_back('{1'b0, 3, R_CNT, 32'h1234_5678, 32'h0});
        tbl.push_back('{1'b1, 3, R_CNT, 32'h0, 32'h1234_5678});
        tbl.push_back('{1'b0, 5, R_EXP, 32'h0000_0077, 32'h0});
        tbl.push_back('{1'b1, 5, R_EXP, 32'h0, 32'h0});
        tbl.push_back('{1'b1, 1, R_EXP, 32'h0, 32'h0000_00A5});
        tbl.push_back('{1'b0, 5, R_CTRL, 32'h0000_0007, 32'h0});
        tbl.push_back('{1'b1, 5, R_CTRL, 32'h0, 32'h0});
        tbl.push_back('{1'b1, 1, R_CTRL, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 3, R_STAT, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back('{1'b1, 3, R_STAT, 32'h0, 32'h0});

        foreach (tbl[i]) begin
            if (tbl[i].r) rd(tbl[i].ch, tbl[i].rg, tbl[i].exp, $sformatf("tbl%0d", i));
            else          wr(tbl[i].ch, tbl[i].rg, tbl[i].wd);
            tick(1);
            chk("idle_rdy", 32'(rdy_), 32'(1'b1));
            chk("idle_rd_data", rd_data, 32'h0);
        end

        // Periodic ch0: COUNT 0..9,0; irq rises one cycle after the flag.
        do_reset();
        wr(0, R_EXP, 9);
        wr(0, R_CTRL, 32'h7);
        for (int m = 1; m <= 12; m++) begin
            rd(0, R_CNT, 32'((m - 1) % 10), "t2_count");
            chk("t2_irq", 32'(irq), 32'(m >= 11));
        end
        rd(0, R_STAT, 32'h1, "t2_flag");
        wr(0, R_CTRL, 32'h0);
        wr(0, R_STAT, 32'h0);
        tick(1);
        chk("t2_irq_off", 32'(irq), 32'(1'b0));

        // One-shot ch1: start auto-clears, COUNT parks at 0, STAT write drops irq.
        wr(1, R_EXP, 3);
        wr(1, R_CTRL, 32'h5);
        tick(10);
        rd(1, R_CTRL, 32'h4, "t3_ctrl");
        rd(1, R_CNT, 32'h0, "t3_count");
        rd(1, R_STAT, 32'h1, "t3_flag");
        chk("t3_irq_on", 32'(irq), 32'(1'b1));
        wr(1, R_STAT, 32'h0);
        chk("t3_irq_hold", 32'(irq), 32'(1'b1));
        tick(1);
        chk("t3_irq_off", 32'(irq), 32'(1'b0));

        // CTRL write on the one-shot auto-clear cycle keeps start.
        wr(1, R_CNT, 0);
        wr(1, R_EXP, 1);
        wr(1, R_CTRL, 32'h1);
        tick(1);
        wr(1, R_CTRL, 32'h1);
        rd(1, R_CTRL, 32'h1, "t4_ctrl_wins");
        wr(1, R_CTRL, 32'h0);
        wr(1, R_STAT, 32'h0);

        // ch2: STAT clear on the firing cycle loses; COUNT write beats increment.
        wr(2, R_EXP, 4);
        wr(2, R_CTRL, 32'h3);
        tick(4);
        wr(2, R_STAT, 32'h0);
        rd(2, R_STAT, 32'h1, "t4_set_wins");
        wr(2, R_CNT, 5);
        rd(2, R_CNT, 32'h5, "t4_count_wins");
        wr(2, R_CTRL, 32'h0);
        wr(2, R_STAT, 32'h0);

        // ch0 and ch3 fire; only ch3 has ie.
        do_reset();
        wr(0, R_EXP, 2);
        wr(0, R_CTRL, 32'h3);
        wr(3, R_EXP, 5);
        wr(3, R_CTRL, 32'h5);
        for (int m = 1; m <= 10; m++) begin
            tick(1);
            chk("t5_irq", 32'(irq), 32'(m >= 7));
        end
        rd(0, R_STAT, 32'h1, "t5_ch0_flag");
        rd(3, R_STAT, 32'h1, "t5_ch3_flag");

`ifdef TIMER_MC_PRESCALE_EN
        // PSC=3, EXPIRE=2: three ticks of four cycles each.
        do_reset();
        wr(0, R_EXP, 2);
        wr(0, R_CTRL, 32'h0307);
        for (int m = 1; m <= 15; m++) begin
            tick(1);
            chk("t6_irq", 32'(irq), 32'(m >= 13));
        end
`else
        do_reset();
        wr(0, R_CTRL, 32'h0307);
        rd(0, R_CTRL, 32'h0007, "t6_no_psc");
`endif

        // Reset coinciding with an access drops rdy_ and clears running state.
        do_reset();
        wr(0, R_EXP, 1);
        wr(0, R_CTRL, 32'h7);
        tick(5);
        chk("rst_pre_irq", 32'(irq), 32'(1'b1));
        reset = 1'b1; cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 30'(R_CNT);
        @(posedge clk); #1;
        reset = 1'b0; cs_ = 1'b1; as_ = 1'b1; addr = '0;
        chk("rst_rdy", 32'(rdy_), 32'(1'b1));
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_irq", 32'(irq), 32'(1'b0));
        rd(0, R_CNT, 32'h0, "rst_count");
        rd(0, R_STAT, 32'h0, "rst_flag");
        rd(0, R_CTRL, 32'h0, "rst_ctrl");

        // Random trials against closed-form expectations:
        // after j ticks a periodic channel holds j mod (E+1); a one-shot holds j up to E, then 0.
        do_reset();
        for (int t = 0; t < 40; t++) begin
            c   = int'($urandom_range(0, 3));
            e   = int'($urandom_range(0, 12));
            k   = int'($urandom_range(0, 30));
            per = int'($urandom_range(0, 1));
            ie  = int'($urandom_range(0, 1));
            wr(c, R_CNT, 0);
            wr(c, R_STAT, 0);
            wr(c, R_EXP, 32'(e));
            wr(c, R_CTRL, 32'(ie * 4 + per * 2 + 1));
            tick(k);
            if (per != 0)   exp_cnt = 32'(k % (e + 1));
            else if (k <= e) exp_cnt = 32'(k);
            else            exp_cnt = 32'h0;
            rd(c, R_CNT, exp_cnt, "rnd_count");
            rd(c, R_STAT, 32'(k >= e), "rnd_flag");
            chk("rnd_irq", 32'(irq), 32'((ie != 0) && (k >= e)));
            st = (per != 0 || (k + 2 <= e)) ? 1 : 0;
            rd(c, R_CTRL, 32'(ie * 4 + per * 2 + st), "rnd_ctrl");
            wr(c, R_CTRL, 0);
            wr(c, R_STAT, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
